rd_initiator: RTL and testbench
===============================

# rd_initiator

Read initiator for the addr/data/rdy responder interface used by the mod-family blocks. It accepts a burst command (start address plus beat count), drives addresses one at a time with a request strobe, and waits for the responder's `rdy` with a bounded timeout. Each returned `data` word, or a timeout error, is forwarded on a valid/ready result stream. It sits between a command source (sequencer or test harness) and one responder instance.

## Interface
Parameters:
- ADDR, 22, address width in bits.
- DATA, 5, data width in bits.
- LEN, 4, burst-length field width; a burst is `cmd_len+1` beats.
- WAIT, 10, max cycles to wait for `rdy` per beat; 0 disables the timeout.

Ports:
- clk  input  1  clock; everything is on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when `cmd_valid && cmd_ready`.
- cmd_addr  input  ADDR  burst start address.
- cmd_len  input  LEN  beats minus 1.
- req  output  1  read request to the responder.
- addr  output  ADDR  address of the current beat.
- rdy  input  1  responder has valid `data`.
- data  input  DATA  responder read data.
- res_valid  output  1  result word present.
- res_ready  input  1  result consumed when `res_valid && res_ready`.
- res_data  output  DATA  captured data; 0 on error.
- res_err  output  1  beat timed out.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a burst ends.

## Operation
- The state machine has three states: IDLE, REQ and OUT.
- IDLE:
  - `cmd_ready=1`.
  - On a command handshake, latch `cur_addr=cmd_addr` and `remaining=cmd_len`, clear `wait_cnt`, and go to REQ.
- REQ:
  - `req=1` and `addr=cur_addr`; `wait_cnt` increments every cycle.
  - If `rdy=1`: register `res_data=data` and `res_err=0`, then go to OUT.
  - Otherwise, if `WAIT!=0` and `wait_cnt==WAIT-1`: register `res_data=0` and `res_err=1`, then go to OUT.
  - If `rdy` arrives in the same cycle as the timeout, it wins: the beat is a success.
- OUT:
  - `res_valid=1` and `req=0`; `res_data` and `res_err` are held stable until the handshake.
  - On `res_ready`, there are three cases:
    - `res_err=1`: go to IDLE and pulse `done`. The rest of the burst is aborted.
    - `remaining==0`: go to IDLE and pulse `done`.
    - Otherwise: `cur_addr=cur_addr+1` (wraps modulo 2^ADDR), `remaining-=1`, clear `wait_cnt`, and go to REQ.
- `rdy` is ignored outside REQ.
- `cmd_ready=0` outside IDLE, so commands are never queued.
- `addr` holds its last value outside REQ. `req` is the only qualifier for `addr`.
- Size `wait_cnt` to hold `WAIT-1` (minimum 1 bit). It saturates and does not wrap when `WAIT=0`.

## Timing
- Reset values (when `rst=0`, asynchronously):
  - state=IDLE.
  - `cmd_ready=0` while reset is asserted; it goes to 1 on the first cycle after release.
  - `req=0`, `addr=0`, `res_valid=0`, `res_data=0`, `res_err=0`, `busy=0`, `done=0`.
  - `cur_addr=0`, `remaining=0`, `wait_cnt=0`.
- All outputs are registered or decoded directly from registered state; there is no combinational path from `rdy` or `res_ready` to any output.
- Latency, taking the command handshake at edge 0:
  - `req` is high from cycle 1.
  - If `rdy` is high in cycle 1, `res_valid` is high in cycle 2.
  - With `res_ready` held high, the next `req` is in cycle 3, so peak throughput is one beat every 2 cycles.
- `req` deasserts in the cycle after `rdy` is sampled high.
- The responder must not expect `req` to stay high in the cycle after `rdy`.
- Timeout:
  - `res_err` is registered at the end of the WAIT-th REQ cycle.
  - With `WAIT=10`, a beat whose `req` rises in cycle 1 times out at the edge ending cycle 10, and the error result is visible in cycle 11.
- `done` is asserted in the cycle after the final result handshake, in the same cycle IDLE is entered.
- A command can be accepted in that same cycle.
- Reset asserted mid-burst:
  - All state clears immediately; the pending result is discarded.
  - No `done` pulse is produced.

## Test plan
- Single beat:
  - Stimulus: `cmd_addr=0x100`, `cmd_len=0`, responder returns `rdy` 2 cycles after `req` with `data=5'h15`, `res_ready=1`.
  - Required: `addr=0x100` while `req` is high; one result with `res_data=0x15` and `res_err=0`; `done` pulses once; `busy` falls.
- Burst with backpressure:
  - Stimulus: `cmd_addr=0x3FFFFE` (ADDR=22), `cmd_len=3`, `res_ready` toggled 1-0-0-1.
  - Required: addresses 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001 in that order; each result held stable while `res_ready=0`; 4 results; one `done`.
- Timeout:
  - Stimulus: `cmd_len=2`, `rdy` never asserted, WAIT=10.
  - Required: `res_valid` rises exactly 10 cycles after `req`; `res_err=1` and `res_data=0`; after the handshake the block returns to IDLE with `done`, and no further `req` is issued.
- `rdy` on the timeout cycle:
  - Stimulus: `rdy=1` exactly on the 10th REQ cycle with `data=5'h0A`.
  - Required: `res_err=0` and `res_data=0x0A`.
- Stray `rdy` and command blocking:
  - Stimulus: pulse `rdy` while in IDLE and OUT; assert `cmd_valid` while busy.
  - Required: no extra results; `cmd_ready` stays 0 until the burst ends; the second command is then accepted and runs normally.
- Reset mid-burst:
  - Stimulus: `rst=0` for 1 cycle during beat 2 of a 4-beat burst.
  - Required: all outputs reach their reset values immediately; no `done`; a new command after release starts from its own `cmd_addr`.

Source files
------------

// File: rtl/rd_initiator.sv
// Read initiator: takes a burst command, issues one request per beat to an
// addr/data/rdy responder with a bounded wait, and streams each result out.
module rd_initiator #(
   parameter int ADDR = 22,
   parameter int DATA = 5,
   parameter int LEN  = 4,
   parameter int WAIT = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [ADDR-1:0] cmd_addr,
   input  logic [LEN-1:0]  cmd_len,
   output logic            req,
   output logic [ADDR-1:0] addr,
   input  logic            rdy,
   input  logic [DATA-1:0] data,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [DATA-1:0] res_data,
   output logic            res_err,
   output logic            busy,
   output logic            done,
   output logic [1:0]      dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // the sender holds its payload stable until then, and ready never
   // depends combinationally on valid.

   localparam int WW = (WAIT <= 1) ? 1 : $clog2(WAIT);
   localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT == 0) ? 0 : WAIT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [ADDR-1:0] cur_addr, cur_addr_nx;
   logic [LEN-1:0]  remaining, remaining_nx;
   logic [WW-1:0]   wait_cnt, wait_cnt_nx;
   logic [DATA-1:0] res_data_q, res_data_nx;
   logic            res_err_q, res_err_nx;
   logic            cmd_ready_q, cmd_ready_nx;
   logic            done_q, done_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cur_addr    <= '0;
         remaining   <= '0;
         wait_cnt    <= '0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         cmd_ready_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_nx;
         cur_addr    <= cur_addr_nx;
         remaining   <= remaining_nx;
         wait_cnt    <= wait_cnt_nx;
         res_data_q  <= res_data_nx;
         res_err_q   <= res_err_nx;
         cmd_ready_q <= cmd_ready_nx;
         done_q      <= done_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      cur_addr_nx  = cur_addr;
      remaining_nx = remaining;
      wait_cnt_nx  = wait_cnt;
      res_data_nx  = res_data_q;
      res_err_nx   = res_err_q;
      done_nx      = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               cur_addr_nx  = cmd_addr;
               remaining_nx = cmd_len;
               wait_cnt_nx  = '0;
               state_nx     = REQ;
            end
         end
         REQ: begin
            // Saturating count keeps WAIT=0 (no timeout) from wrapping.
            if (wait_cnt != {WW{1'b1}}) begin
               wait_cnt_nx = wait_cnt + 1'b1;
            end
            // A response on the final wait cycle still counts as success.
            if (rdy) begin
               res_data_nx = data;
               res_err_nx  = 1'b0;
               state_nx    = OUT;
            end else if ((WAIT != 0) && (wait_cnt == WAIT_LAST)) begin
               res_data_nx = '0;
               res_err_nx  = 1'b1;
               state_nx    = OUT;
            end
         end
         OUT: begin
            if (res_ready) begin
               if (res_err_q || (remaining == '0)) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end else begin
                  cur_addr_nx  = cur_addr + 1'b1;
                  remaining_nx = remaining - 1'b1;
                  wait_cnt_nx  = '0;
                  state_nx     = REQ;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // Registered so it reads 0 during reset and rises one edge after release.
      cmd_ready_nx = (state_nx == IDLE);
   end

   assign cmd_ready = cmd_ready_q;
   assign req       = (state == REQ);
   assign addr      = cur_addr;
   assign res_valid = (state == OUT);
   assign res_data  = res_data_q;
   assign res_err   = res_err_q;
   assign busy      = (state != IDLE);
   assign done      = done_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_rd_initiator.sv
// Directed bench for rd_initiator: hand-computed beats, a result scoreboard
// fed from an expected queue, and one summary line at the end.
module tb_rd_initiator;

   localparam int ADDR = 22;
   localparam int DATA = 5;
   localparam int LEN  = 4;
   localparam int WAIT = 10;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [ADDR-1:0] cmd_addr = '0;
   logic [LEN-1:0]  cmd_len = '0;
   logic            req;
   logic [ADDR-1:0] addr;
   logic            rdy = 1'b0;
   logic [DATA-1:0] data = '0;
   logic            res_valid;
   logic            res_ready = 1'b1;
   logic [DATA-1:0] res_data;
   logic            res_err;
   logic            busy;
   logic            done;
   logic [1:0]      dbg_state;

   rd_initiator #(.ADDR(ADDR), .DATA(DATA), .LEN(LEN), .WAIT(WAIT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .req(req), .addr(addr), .rdy(rdy), .data(data),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_err(res_err),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_res    = 0;
   int n_done   = 0;

   logic [DATA:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: every result handshake is compared against the expected queue
   always @(negedge clk) begin
      if (rst && res_valid && res_ready) begin
         n_res++;
         if (exp_q.size() > 0) begin
            check("res_word", 32'({res_err, res_data}), 32'(exp_q.pop_front()));
         end
      end
      if (rst && done) n_done++;
   end

   // driver tasks
   task automatic send_cmd(input logic [ADDR-1:0] a, input logic [LEN-1:0] l);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = l;
      for (int i = 0; i < 20 && !cmd_ready; i++) tick();
      check("cmd_ready_idle", 32'(cmd_ready), 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic do_beat(input logic [ADDR-1:0] a, input logic [DATA-1:0] d,
                          input int lat, input int hold);
      for (int i = 0; i < lat; i++) begin
         check("req_wait", 32'(req), 1);
         check("addr_wait", 32'(addr), 32'(a));
         tick();
      end
      check("req", 32'(req), 1);
      check("addr", 32'(addr), 32'(a));
      check("cmd_ready_busy", 32'(cmd_ready), 0);
      rdy  = 1'b1;
      data = d;
      exp_q.push_back({1'b0, d});
      res_ready = (hold == 0);
      tick();
      rdy  = 1'b0;
      data = '0;
      check("res_valid", 32'(res_valid), 1);
      check("req_low", 32'(req), 0);
      check("res_data", 32'(res_data), 32'(d));
      check("res_err", 32'(res_err), 0);
      for (int i = 0; i < hold; i++) begin
         rdy = 1'b1;
         tick();
         check("hold_valid", 32'(res_valid), 1);
         check("hold_data", 32'(res_data), 32'(d));
      end
      rdy = 1'b0;
      res_ready = 1'b1;
      tick();
   endtask

   task automatic check_done_cycle(input string tag);
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_req"}, 32'(req), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
      check({tag, "_req"}, 32'(req), 0);
      check({tag, "_addr"}, 32'(addr), 0);
      check({tag, "_res_valid"}, 32'(res_valid), 0);
      check({tag, "_res_data"}, 32'(res_data), 0);
      check({tag, "_res_err"}, 32'(res_err), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_state"}, 32'(dbg_state), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #1;
      check_reset_outputs("rst");
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("cmd_ready_after_rst", 32'(cmd_ready), 1);

      // single beat, rdy two cycles after req
      send_cmd(22'h100, 4'd0);
      check("t1_busy", 32'(busy), 1);
      do_beat(22'h100, 5'h15, 2, 0);
      check_done_cycle("t1");
      tick();
      check("t1_done_pulse", 32'(done), 0);
      check("t1_nres", 32'(n_res), 1);
      check("t1_ndone", 32'(n_done), 1);

      // wrapping burst with backpressure 1-0-0-1
      send_cmd(22'h3FFFFE, 4'd3);
      do_beat(22'h3FFFFE, 5'h01, 0, 0);
      do_beat(22'h3FFFFF, 5'h02, 0, 2);
      do_beat(22'h000000, 5'h03, 0, 2);
      do_beat(22'h000001, 5'h04, 0, 0);
      check_done_cycle("t2");
      tick();
      check("t2_nres", 32'(n_res), 5);
      check("t2_ndone", 32'(n_done), 2);

      // timeout: result appears 10 cycles after req rises, burst aborts
      data = 5'h1F;
      send_cmd(22'h0ABCDE, 4'd2);
      for (int i = 0; i < WAIT; i++) begin
         check("to_req", 32'(req), 1);
         check("to_no_valid", 32'(res_valid), 0);
         tick();
      end
      exp_q.push_back({1'b1, 5'h00});
      check("to_valid", 32'(res_valid), 1);
      check("to_err", 32'(res_err), 1);
      check("to_data", 32'(res_data), 0);
      tick();
      check_done_cycle("t3");
      for (int i = 0; i < 5; i++) tick();
      check("to_no_req", 32'(req), 0);
      check("t3_nres", 32'(n_res), 6);
      check("t3_ndone", 32'(n_done), 3);
      data = '0;

      // rdy on the final wait cycle wins over the timeout
      send_cmd(22'h00002A, 4'd0);
      do_beat(22'h00002A, 5'h0A, WAIT - 1, 0);
      check_done_cycle("t4");
      tick();
      check("t4_nres", 32'(n_res), 7);

      // stray rdy in IDLE, command offered while busy
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      check("stray_req", 32'(req), 0);
      check("stray_valid", 32'(res_valid), 0);
      send_cmd(22'h000200, 4'd1);
      cmd_valid = 1'b1;
      cmd_addr  = 22'h000300;
      cmd_len   = 4'd0;
      do_beat(22'h000200, 5'h11, 1, 1);
      check("t5_cmd_blocked", 32'(cmd_ready), 0);
      do_beat(22'h000201, 5'h12, 0, 0);
      check_done_cycle("t5a");
      check("t5_cmd_ready", 32'(cmd_ready), 1);
      tick();
      cmd_valid = 1'b0;
      do_beat(22'h000300, 5'h13, 0, 0);
      check_done_cycle("t5b");
      tick();
      check("t5_nres", 32'(n_res), 10);
      check("t5_ndone", 32'(n_done), 6);

      // reset asserted during beat 2 of a 4-beat burst
      send_cmd(22'h000040, 4'd3);
      do_beat(22'h000040, 5'h05, 0, 0);
      check("t6_req_beat2", 32'(req), 1);
      check("t6_addr_beat2", 32'(addr), 32'h41);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      tick();
      check_reset_outputs("mid_rst_hold");
      rst = 1'b1;
      send_cmd(22'h000155, 4'd0);
      do_beat(22'h000155, 5'h1F, 0, 0);
      check_done_cycle("t6");
      tick();
      check("t6_nres", 32'(n_res), 12);
      check("t6_ndone", 32'(n_done), 7);

      check("exp_q_drained", 32'(exp_q.size()), 0);

      // final report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
